// File: rtl/om_result_streamer.sv
// Streams a window of OutputMemory distances over a valid/ready interface,
// flagging unreachable vertices (distance == INF_VALUE).
//
// state  | meaning
// IDLE   | waiting for start; OMAR holds its last value
// STREAM | fetching words from OutputMemory and presenting them to the consumer
// FINISH | one-cycle done pulse, then back to IDLE
module om_result_streamer #(
   parameter int                ADDR_W    = 13,
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] INF_VALUE = {DATA_W{1'b1}}
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] count,
   output logic [ADDR_W-1:0] OMAR,
   input  logic [DATA_W-1:0] OMDR,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_unreach,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              unreach_q, unreach_d;
   logic              valid_q, valid_d;
   logic              load;
   logic              accept;
   logic              last_accept;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         count_q   <= '0;
         rd_idx_q  <= '0;
         data_q    <= '0;
         idx_q     <= '0;
         unreach_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         count_q   <= count_d;
         rd_idx_q  <= rd_idx_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         unreach_q <= unreach_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      count_d     = count_q;
      rd_idx_d    = rd_idx_q;
      data_d      = data_q;
      idx_d       = idx_q;
      unreach_d   = unreach_q;
      valid_d     = valid_q;
      load        = 1'b0;
      accept      = valid_q && out_ready;
      last_accept = accept && (idx_q == count_q - ADDR_W'(1));

      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (start) begin
               base_d   = base_addr;
               count_d  = count;
               rd_idx_d = '0;
               state_d  = (count == '0) ? FINISH : STREAM;
            end
         end

         STREAM: begin
            // A slot is free when nothing is held or the held word leaves this edge.
            load = (!valid_q || out_ready) && (rd_idx_q < count_q);
            if (load) begin
               data_d    = OMDR;
               idx_d     = rd_idx_q;
               unreach_d = (OMDR == INF_VALUE);
               valid_d   = 1'b1;
               rd_idx_d  = rd_idx_q + ADDR_W'(1);
            end else if (accept) begin
               valid_d = 1'b0;
            end
            if (last_accept) begin
               state_d = FINISH;
            end
         end

         FINISH: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end

         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Address wraps naturally at 2^ADDR_W; base/rd_idx hold in IDLE so OMAR does too.
   assign OMAR        = base_q + rd_idx_q;
   assign out_data    = data_q;
   assign out_index   = idx_q;
   assign out_unreach = unreach_q;
   assign out_valid   = valid_q;
   assign busy        = (state_q == STREAM) || (state_q == FINISH);
   assign done        = (state_q == FINISH);

endmodule

// File: tb/tb_om_result_streamer.sv
// Directed bench for om_result_streamer: a memory model drives OMDR and
// each delivered word is compared against that model.
module tb_om_result_streamer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [12:0] base_addr;
   logic [12:0] count;
   logic [12:0] OMAR;
   logic [15:0] OMDR;
   logic [15:0] out_data;
   logic [12:0] out_index;
   logic        out_unreach;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   logic [15:0] mem [0:8191];
   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clock = ~clock;
   assign OMDR = mem[OMAR];

   om_result_streamer dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .count       (count),
      .OMAR        (OMAR),
      .OMDR        (OMDR),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_unreach (out_unreach),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // ready_mode 0: always ready; 1: ready pattern 1,0,0 repeating.
   // inject: pulse a second start (base 0, count 9) two cycles into the transfer.
   task automatic run_xfer(input logic [12:0] b, input logic [12:0] c,
                           input int ready_mode, input bit inject);
      int          cyc      = 0;
      int          exp_idx  = 0;
      int          n_done   = 0;
      bit          finished = 0;
      bit          stalled  = 0;
      logic [15:0] prev_data;
      logic [12:0] prev_idx;
      logic [12:0] a;
      start     = 1'b1;
      base_addr = b;
      count     = c;
      out_ready = (ready_mode == 0);
      tick();
      start = 1'b0;
      chk("xfer_busy_after_start", busy, 1'b1);
      chk("xfer_omar_first", OMAR, b);
      while (!finished && cyc < 200) begin
         tick();
         cyc++;
         start = inject && (cyc == 2);
         if (start) begin
            base_addr = 13'd0;
            count     = 13'd9;
         end
         out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 1);
         if (stalled) begin
            chk("xfer_hold_data", out_data, prev_data);
            chk("xfer_hold_index", out_index, prev_idx);
            chk("xfer_hold_valid", out_valid, 1'b1);
         end
         if (done) begin
            finished = 1;
            n_done++;
            chk("xfer_done_no_valid", out_valid, 1'b0);
            chk("xfer_done_busy", busy, 1'b1);
         end else if (out_valid) begin
            a = b + 13'(exp_idx);
            chk("xfer_index", out_index, 13'(exp_idx));
            chk("xfer_data", out_data, mem[a]);
            chk("xfer_unreach", out_unreach, mem[a] == 16'hFFFF);
         end
         stalled   = out_valid && !out_ready;
         prev_data = out_data;
         prev_idx  = out_index;
         if (out_valid && out_ready) exp_idx++;
      end
      chk("xfer_no_timeout", finished, 1'b1);
      chk("xfer_word_count", exp_idx, 32'(c));
      start = 1'b0;
      tick();
      chk("xfer_done_once", done, 1'b0);
      chk("xfer_idle_busy", busy, 1'b0);
      chk("xfer_idle_valid", out_valid, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] e1 [4];
      e1 = '{16'd5, 16'd0, 16'hFFFF, 16'd12};
      for (int i = 0; i < 8192; i++) mem[i] = 16'(i * 3 + 7);
      mem[100] = 16'd5;   mem[101] = 16'd0;   mem[102] = 16'hFFFF; mem[103] = 16'd12;
      mem[8190] = 16'h1111; mem[8191] = 16'hFFFF; mem[0] = 16'h2222; mem[1] = 16'h3333;

      reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_data", out_data, 16'd0);
      chk("rst_index", out_index, 13'd0);
      chk("rst_unreach", out_unreach, 1'b0);
      chk("rst_omar", OMAR, 13'd0);
      reset = 1'b0;
      tick();

      // 1: cycle-exact stream with ready held high
      start = 1'b1; base_addr = 13'd100; count = 13'd4; out_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_busy0", busy, 1'b1);
      chk("t1_valid0", out_valid, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t1_valid", out_valid, 1'b1);
         chk("t1_data", out_data, e1[k]);
         chk("t1_index", out_index, 13'(k));
         chk("t1_unreach", out_unreach, k == 2);
         chk("t1_busy", busy, 1'b1);
         chk("t1_done_low", done, 1'b0);
      end
      tick();
      chk("t1_done", done, 1'b1);
      chk("t1_busy_fin", busy, 1'b1);
      chk("t1_valid_fin", out_valid, 1'b0);
      tick();
      chk("t1_done_off", done, 1'b0);
      chk("t1_busy_off", busy, 1'b0);

      // 2: backpressure
      run_xfer(13'd100, 13'd4, 1, 1'b0);
      // 3: window wrapping past the top of memory
      run_xfer(13'd8190, 13'd4, 0, 1'b0);
      // 5: start mid-transfer is ignored
      run_xfer(13'd100, 13'd4, 0, 1'b1);

      // 4: zero-length transfer
      start = 1'b1; base_addr = 13'd50; count = 13'd0; out_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_done", done, 1'b1);
      chk("t4_busy", busy, 1'b1);
      chk("t4_valid", out_valid, 1'b0);
      tick();
      chk("t4_done_off", done, 1'b0);
      chk("t4_busy_off", busy, 1'b0);
      chk("t4_valid_off", out_valid, 1'b0);

      // 6: reset after two words accepted
      start = 1'b1; base_addr = 13'd100; count = 13'd4; out_ready = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("t6_pre_index", out_index, 13'd2);
      chk("t6_pre_valid", out_valid, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_valid", out_valid, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_omar", OMAR, 13'd0);
      tick();
      chk("t6_no_done", done, 1'b0);
      chk("t6_idle", busy, 1'b0);
      run_xfer(13'd100, 13'd4, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
